// File: rtl/mem_chk_pkg.sv
// rtl/mem_chk_pkg.sv - shared types and constants for the memory checker
// Contents: mem_chk_state_t (controller state), ERR_CNT_W (error counter width).
package mem_chk_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } mem_chk_state_t;

endpackage

// File: rtl/mem_chk_cmp.sv
// rtl/mem_chk_cmp.sv - per-word parity / pattern check for the memory checker
// Ports: word (stored {parity, data}), expected (pattern written), err (word is faulty).
// Build option: MEM_CHK_DATA_CMP_EN adds a data-vs-pattern compare to the parity check.
module mem_chk_cmp
    import mem_chk_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W:0]   word,
    input  logic [DATA_W-1:0] expected,
    output logic              err
);

    logic parity_err;

    // Stored words carry even parity across all DATA_W+1 bits.
    assign parity_err = ^word;

`ifdef MEM_CHK_DATA_CMP_EN
    // A word failing both tests still produces a single err.
    assign err = parity_err | (word[DATA_W-1:0] != expected);
`else
    logic unused_expected;
    assign unused_expected = ^expected;
    assign err = parity_err;
`endif

endmodule

// File: rtl/mem_checker.sv
// rtl/mem_checker.sv - write-then-read-back memory test controller
// Ports: clk, rst_n (async active-low); start/abort control; base_addr/count/seed run setup;
//        write/read/address/data_in to the target, data_out ({parity, data}) from it;
//        busy, done (1-cycle pulse), err_flag, err_count (saturating), first_err_addr results.
// Build option: MEM_CHK_DATA_CMP_EN (see mem_chk_cmp) enables data-pattern comparison.
module mem_checker
    import mem_chk_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    count,
    input  logic [DATA_W-1:0]    seed,
    output logic                 write,
    output logic                 read,
    output logic [DATA_W-1:0]    data_in,
    output logic [ADDR_W-1:0]    address,
    input  logic [DATA_W:0]      data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_addr
);

    mem_chk_state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] seed_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] pattern;
    logic              last_word;
    logic              word_err;
    logic              start_run;

    // Adder width equals ADDR_W, so the walk wraps through zero naturally.
    assign cur_addr  = base_q + idx_q;
    assign pattern   = DATA_W'(cur_addr) ^ seed_q;
    assign last_word = (idx_q == count_q - ADDR_W'(1));
    assign start_run = (state == ST_IDLE) && start && !abort;

    mem_chk_cmp #(.DATA_W(DATA_W)) u_cmp (
        .word     (data_out),
        .expected (pattern),
        .err      (word_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        write     = 1'b0;
        read      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (count == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                write = 1'b1;
                busy  = 1'b1;
                if (last_word) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                read      = 1'b1;
                busy      = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy      = 1'b1;
                state_nxt = last_word ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    assign address = (write || read) ? cur_addr : '0;
    assign data_in = write ? pattern : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q         <= '0;
            count_q        <= '0;
            seed_q         <= '0;
            idx_q          <= '0;
            err_flag       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (start_run) begin
            base_q         <= base_addr;
            count_q        <= count;
            seed_q         <= seed;
            idx_q          <= '0;
            err_flag       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (!abort) begin
            case (state)
                ST_WRITE: begin
                    // Restart the index for the read-back pass.
                    idx_q <= last_word ? '0 : idx_q + ADDR_W'(1);
                end
                ST_CHECK: begin
                    if (word_err) begin
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_CNT_W'(1);
                        end
                        if (!err_flag) begin
                            err_flag       <= 1'b1;
                            first_err_addr <= cur_addr;
                        end
                    end
                    if (!last_word) begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_checker.sv
// tb/tb_mem_checker.sv - self-checking bench for mem_checker with a behavioural target memory
module tb_mem_checker;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] count = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              write, read, busy, done, err_flag;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] address, first_err_addr;
    logic [DATA_W:0]   data_out = '0;
    logic [15:0]       err_count;

    always #5 clk = ~clk;

    mem_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .count          (count),
        .seed           (seed),
        .write          (write),
        .read           (read),
        .data_in        (data_in),
        .address        (address),
        .data_out       (data_out),
        .busy           (busy),
        .done           (done),
        .err_flag       (err_flag),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Target memory: stores even parity, registers read data; optional fault injection.
    logic [DATA_W:0]   mem [0:(1<<ADDR_W)-1];
    bit                par_on = 0, dat_on = 0;
    logic [ADDR_W-1:0] par_addr = '0, dat_addr = '0;

    function automatic logic [DATA_W:0] target_word(input logic [DATA_W:0] w, input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        r = w;
        if (par_on && a == par_addr) r[DATA_W] = ~r[DATA_W];
        if (dat_on && a == dat_addr) r[1:0] = ~r[1:0];
        return r;
    endfunction

    always @(posedge clk) begin
        if (write) mem[address] <= {^data_in, data_in};
        if (read)  data_out <= target_word(mem[address], address);
    end

    int overlap_cnt = 0;
    int stray_cnt = 0;
    always @(negedge clk) begin
        if (write && read) overlap_cnt++;
        if (!busy && (write || read)) stray_cnt++;
    end

    bit cmp_en;
    initial begin
`ifdef MEM_CHK_DATA_CMP_EN
        cmp_en = 1;
`else
        cmp_en = 0;
`endif
    end

    task automatic check_zero(input string tag);
        check_val({tag, "_write"}, 32'(write), 0);
        check_val({tag, "_read"}, 32'(read), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_err_flag"}, 32'(err_flag), 0);
        check_val({tag, "_data_in"}, 32'(data_in), 0);
        check_val({tag, "_address"}, 32'(address), 0);
        check_val({tag, "_err_count"}, 32'(err_count), 0);
        check_val({tag, "_first_err"}, 32'(first_err_addr), 0);
    endtask

    // One complete run compared against the reference list of accesses and errors.
    task automatic run_test(input string tag, input logic [ADDR_W-1:0] base,
                            input logic [ADDR_W-1:0] cnt, input logic [DATA_W-1:0] sd,
                            input bit poke_busy);
        logic [ADDR_W+DATA_W-1:0] exp_wr[$], got_wr[$];
        logic [ADDR_W-1:0]        exp_rd[$], got_rd[$];
        logic [ADDR_W-1:0]        a, exp_first;
        int n, exp_err, cyc;
        n = int'(cnt);
        exp_err = 0;
        exp_first = '0;
        for (int i = 0; i < n; i++) begin
            a = (base + ADDR_W'(i)) % (1 << ADDR_W);
            exp_wr.push_back({a, a[7:0] ^ sd});
            exp_rd.push_back(a);
            if ((par_on && a == par_addr) || (cmp_en && dat_on && a == dat_addr)) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end

        @(negedge clk);
        base_addr = base; count = cnt; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        forever begin
            if (write) got_wr.push_back({address, data_in});
            if (read)  got_rd.push_back(address);
            if (done || cyc >= 3 * n + 20) break;
            if (poke_busy && cyc == 2) begin
                start = 1'b1; base_addr = ~base; count = cnt + 3; seed = ~sd;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check_val({tag, "_done_seen"}, 32'(done), 1);
        check_val({tag, "_done_cycle"}, 32'(cyc), 32'(3 * n + 1));
        check_val({tag, "_n_writes"}, 32'(got_wr.size()), 32'(n));
        check_val({tag, "_n_reads"}, 32'(got_rd.size()), 32'(n));
        for (int i = 0; i < n && i < got_wr.size(); i++)
            check_val($sformatf("%s_wr%0d", tag, i), 32'(got_wr[i]), 32'(exp_wr[i]));
        for (int i = 0; i < n && i < got_rd.size(); i++)
            check_val($sformatf("%s_rd%0d", tag, i), 32'(got_rd[i]), 32'(exp_rd[i]));
        check_val({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        check_val({tag, "_err_flag"}, 32'(err_flag), 32'(exp_err != 0));
        check_val({tag, "_first_err"}, 32'(first_err_addr), 32'(exp_first));
        @(negedge clk);
        check_val({tag, "_done_pulse_end"}, 32'(done), 0);
        check_val({tag, "_idle_busy"}, 32'(busy), 0);
        check_val({tag, "_err_hold"}, 32'(err_count), 32'(exp_err));
    endtask

    initial begin
        int reads_seen, cyc;
        bit saw_done, saw_busy;
        logic [ADDR_W-1:0] rb, rc;

        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_test("basic", 16'h0010, 16'd4, 8'hA5, 0);
        par_on = 1; par_addr = 16'h0012;
        run_test("parity", 16'h0010, 16'd4, 8'hA5, 0);
        par_on = 0; dat_on = 1; dat_addr = 16'h0011;
        run_test("datafault", 16'h0010, 16'd4, 8'hA5, 0);
        dat_on = 0;
        run_test("wrap", 16'hFFFF, 16'd2, 8'h5A, 0);
        run_test("count0", 16'h1234, 16'd0, 8'h00, 0);
        run_test("busystart", 16'h0100, 16'd4, 8'h3C, 1);

        // Abort in the second READ; the error from the first word must be retained.
        par_on = 1; par_addr = 16'h0020;
        @(negedge clk);
        base_addr = 16'h0020; count = 16'd4; seed = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reads_seen = 0;
        cyc = 0;
        while (reads_seen < 2 && cyc < 40) begin
            if (read) reads_seen++;
            if (reads_seen < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        check_val("abort_reached_read2", 32'(reads_seen), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_write", 32'(write), 0);
        check_val("abort_read", 32'(read), 0);
        check_val("abort_busy", 32'(busy), 0);
        saw_done = 0;
        repeat (15) begin
            if (done) saw_done = 1;
            @(negedge clk);
        end
        check_val("abort_no_done", 32'(saw_done), 0);
        check_val("abort_err_count", 32'(err_count), 1);
        check_val("abort_err_flag", 32'(err_flag), 1);
        check_val("abort_first_err", 32'(first_err_addr), 32'h0020);
        par_on = 0;
        run_test("after_abort", 16'h0040, 16'd3, 8'h77, 0);

        // Reset asserted during WRITE.
        @(negedge clk);
        base_addr = 16'h0200; count = 16'd5; seed = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("rstmid_in_write", 32'(write), 1);
        rst_n = 1'b0;
        #1;
        check_zero("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0; saw_busy = 0;
        repeat (10) begin
            if (done) saw_done = 1;
            if (busy) saw_busy = 1;
            @(negedge clk);
        end
        check_val("rstmid_no_done", 32'(saw_done), 0);
        check_val("rstmid_no_busy", 32'(saw_busy), 0);
        run_test("after_reset", 16'h0300, 16'd5, 8'h99, 0);

        // Randomised runs with random fault placement.
        for (int t = 0; t < 8; t++) begin
            rb = ADDR_W'($urandom);
            rc = ADDR_W'($urandom_range(1, 24));
            par_on = bit'($urandom_range(0, 1));
            dat_on = bit'($urandom_range(0, 1));
            par_addr = rb + ADDR_W'($urandom_range(0, int'(rc) - 1));
            dat_addr = rb + ADDR_W'($urandom_range(0, int'(rc) - 1));
            run_test($sformatf("rand%0d", t), rb, rc, DATA_W'($urandom), 0);
        end
        par_on = 0; dat_on = 0;

        check_val("strobe_overlap", 32'(overlap_cnt), 0);
        check_val("strobe_outside_busy", 32'(stray_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_checker.md
MEM_CHECKER -- requirements
Module: mem_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning target address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning payload width; the stored word is DATA_W+1 bits (parity in MSB).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a test run.
REQ-006 SHALL have port abort  input  1  terminate the current run.
REQ-007 SHALL have port base_addr  input  ADDR_W  first address tested.
REQ-008 SHALL have port count  input  ADDR_W  number of words tested.
REQ-009 SHALL have port seed  input  DATA_W  pattern seed.
REQ-010 SHALL have port write  output  1  target write strobe.
REQ-011 SHALL have port read  output  1  target read strobe.
REQ-012 SHALL have port data_in  output  DATA_W  target write payload.
REQ-013 SHALL have port address  output  ADDR_W  target address.
REQ-014 SHALL have port data_out  input  DATA_W+1  target read word, {parity, data}.
REQ-015 SHALL have ports busy (1), done (1), err_flag (1), err_count (16) and first_err_addr (ADDR_W) as outputs, meaning run active, one-cycle completion pulse, any error seen, saturating error count and address of first error.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, CHECK, DONE.
REQ-017 IDLE: on start=1, SHALL latch base_addr/count/seed, clear err_count/err_flag/first_err_addr, and enter WRITE; or enter DONE directly if count=0.
REQ-018 WRITE: SHALL assert write=1 for one cycle per word, address=base+i, data_in=(base+i)[7:0]^seed, for i=0..count-1, then enter READ.
REQ-019 READ: SHALL assert read=1 for one cycle with address=base+i, then enter CHECK.
REQ-020 CHECK: SHALL sample data_out (the target registers it on the edge ending READ), flag an error if XOR of all DATA_W+1 bits is 1, and return to READ for the next word or enter DONE after the last word.
REQ-021 Latency SHALL be 1 cycle per word in WRITE and 2 cycles per word in READ/CHECK; a run of N>0 words takes 3N+1 cycles from start to done.
REQ-022 write and read SHALL never be asserted in the same cycle, and both SHALL be 0 outside WRITE/READ.
REQ-023 Address arithmetic SHALL wrap modulo 2^ADDR_W (base 0xFFFF, count 2 tests 0xFFFF then 0x0000).
REQ-024 On the first error of a run, first_err_addr SHALL capture the address and err_flag SHALL set; err_count SHALL increment per error and saturate at 0xFFFF.
REQ-025 DONE: SHALL pulse done=1 for exactly one cycle, then enter IDLE; results SHALL hold until the next start.
REQ-026 busy SHALL be 1 in WRITE, READ and CHECK, and 0 otherwise.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort SHALL take priority over start and over all other transitions: next state IDLE, strobes deasserted the following cycle, no done pulse, results retained.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and drive write, read, busy, done and err_flag to 0 and data_in, address, err_count and first_err_addr to 0.
REQ-030 Reset mid-run SHALL discard the run; a new start is required after release.

Configuration
REQ-031 With MEM_CHK_DATA_CMP_EN defined, CHECK SHALL also flag an error when data_out[DATA_W-1:0] differs from the expected pattern; a word with both faults counts once.
REQ-032 Without MEM_CHK_DATA_CMP_EN, only parity SHALL be checked.

Structure
REQ-033 A shared package mem_chk_pkg SHALL hold the state enum typedef and the error-counter width constant.
REQ-034 The parity/compare logic SHALL be a sub-module mem_chk_cmp; the FSM and counters SHALL stay in mem_checker.

Verification
REQ-035 base 0x0010, count 4, seed 0xA5, fault-free model -> writes 0xB5,0xB4,0xB7,0xB6 to 0x0010-0x0013; done at cycle 13; err_count 0.
REQ-036 Model flips the parity bit at 0x0012 -> err_count 1, err_flag 1, first_err_addr 0x0012.
REQ-037 Model corrupts data at 0x0011 with correct parity -> err_count 1 with MEM_CHK_DATA_CMP_EN, 0 without.
REQ-038 base 0xFFFF, count 2 -> accesses 0xFFFF then 0x0000; count 0 -> done 1 cycle after start, no strobes.
REQ-039 abort during the second READ, and separately rst_n=0 during WRITE -> IDLE, strobes low, no done pulse; a following start runs normally.
REQ-040 start asserted while busy -> ignored; latched parameters unchanged.
